// File: rtl/updown_pkg.sv
// Shared encodings for the up/down guessing game: result codes, game states
// and the 7-segment glyphs (active-high {g,f,e,d,c,b,a}).
package updown_pkg;

   localparam logic [1:0] RES_NONE    = 2'b00;
   localparam logic [1:0] RES_UP      = 2'b01;
   localparam logic [1:0] RES_DOWN    = 2'b10;
   localparam logic [1:0] RES_CORRECT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_U     = 7'b0111110;
   localparam logic [6:0] SEG_D     = 7'b1011110;
   localparam logic [6:0] SEG_C     = 7'b0111001;
   localparam logic [6:0] SEG_L     = 7'b0111000;

endpackage

// File: rtl/updown_seg_enc.sv
// Combinational glyph selection from game state and last result.
// The game core registers the output before it reaches the display.
module updown_seg_enc
   import updown_pkg::*;
(
   input  state_t     state,
   input  logic [1:0] result,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (state)
         ST_IDLE: seg = SEG_BLANK;
         ST_WIN:  seg = SEG_C;
         ST_LOSE: seg = SEG_L;
         ST_PLAY: begin
            if (result == RES_UP)
               seg = SEG_U;
            else if (result == RES_DOWN)
               seg = SEG_D;
            else
               seg = SEG_BLANK;
         end
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/updown_game_core.sv
// Up/down guessing game core: secret latch, guess handshake, attempt counter,
// win/lose detection, registered result and display. Option: UPDOWN_RANGE_TRACK_EN.
module updown_game_core
   import updown_pkg::*;
#(
   parameter  int NUM_W     = 7,
   parameter  int MAX_NUM   = 99,
   parameter  int MAX_TRIES = 7,
   localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [NUM_W-1:0] secret,
   input  logic             guess_valid,
   input  logic [NUM_W-1:0] guess,
   output logic             guess_ready,
   output logic [1:0]       result,
   output logic             result_valid,
   output logic             guess_err,
   output logic [TRY_W-1:0] tries_used,
   output logic [TRY_W-1:0] tries_left,
   output logic             won,
   output logic             lost,
   output logic [6:0]       seg_display
`ifdef UPDOWN_RANGE_TRACK_EN
   ,
   output logic [NUM_W-1:0] range_lo,
   output logic [NUM_W-1:0] range_hi
`endif
);

   localparam logic [NUM_W-1:0] MAX_NUM_V   = NUM_W'(MAX_NUM);
   localparam logic [TRY_W-1:0] MAX_TRIES_V = TRY_W'(MAX_TRIES);

   state_t           state_reg, state_next;
   logic [NUM_W-1:0] secret_reg, secret_next;
   logic [1:0]       result_reg, result_next;
   logic             result_valid_reg, result_valid_next;
   logic             guess_err_reg, guess_err_next;
   logic [TRY_W-1:0] tries_reg, tries_next;
   logic [6:0]       seg_reg, seg_next;
   logic [NUM_W-1:0] lo_reg, lo_next;
   logic [NUM_W-1:0] hi_reg, hi_next;

   logic             start_ok;
   logic             accept;
   logic             in_range;
   logic [1:0]       cmp_res;
   logic [TRY_W-1:0] tries_inc;

   assign start_ok  = start && (secret <= MAX_NUM_V);
   // A legal start wins over a guess presented in the same cycle.
   assign accept    = guess_valid && (state_reg == ST_PLAY) && !start_ok;
   assign cmp_res   = (secret_reg > guess) ? RES_UP :
                      (secret_reg < guess) ? RES_DOWN : RES_CORRECT;
   assign tries_inc = (tries_reg == MAX_TRIES_V) ? tries_reg : tries_reg + TRY_W'(1);

`ifdef UPDOWN_RANGE_TRACK_EN
   assign in_range = (guess <= MAX_NUM_V) && (guess >= lo_reg) && (guess <= hi_reg);
`else
   assign in_range = (guess <= MAX_NUM_V);
`endif

   always_comb begin
      state_next        = state_reg;
      secret_next       = secret_reg;
      result_next       = result_reg;
      result_valid_next = 1'b0;
      guess_err_next    = 1'b0;
      tries_next        = tries_reg;
      lo_next           = lo_reg;
      hi_next           = hi_reg;
      if (start_ok) begin
         state_next  = ST_PLAY;
         secret_next = secret;
         result_next = RES_NONE;
         tries_next  = '0;
         lo_next     = '0;
         hi_next     = MAX_NUM_V;
      end else if (accept) begin
         if (!in_range) begin
            guess_err_next = 1'b1;
         end else begin
            result_valid_next = 1'b1;
            result_next       = cmp_res;
            tries_next        = tries_inc;
            // A correct guess on the last try still wins.
            if (cmp_res == RES_CORRECT)
               state_next = ST_WIN;
            else if (tries_inc == MAX_TRIES_V)
               state_next = ST_LOSE;
            if (cmp_res == RES_UP)
               lo_next = guess + NUM_W'(1);
            else if (cmp_res == RES_DOWN)
               hi_next = guess - NUM_W'(1);
         end
      end
   end

   // Glyph is computed from next state so the display lines up with state.
   updown_seg_enc u_seg_enc (
      .state  (state_next),
      .result (result_next),
      .seg    (seg_next)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= ST_IDLE;
         secret_reg       <= '0;
         result_reg       <= RES_NONE;
         result_valid_reg <= 1'b0;
         guess_err_reg    <= 1'b0;
         tries_reg        <= '0;
         seg_reg          <= SEG_BLANK;
         lo_reg           <= '0;
         hi_reg           <= MAX_NUM_V;
      end else begin
         state_reg        <= state_next;
         secret_reg       <= secret_next;
         result_reg       <= result_next;
         result_valid_reg <= result_valid_next;
         guess_err_reg    <= guess_err_next;
         tries_reg        <= tries_next;
         seg_reg          <= seg_next;
         lo_reg           <= lo_next;
         hi_reg           <= hi_next;
      end
   end

   assign guess_ready  = (state_reg == ST_PLAY);
   assign result       = result_reg;
   assign result_valid = result_valid_reg;
   assign guess_err    = guess_err_reg;
   assign tries_used   = tries_reg;
   assign tries_left   = MAX_TRIES_V - tries_reg;
   assign won          = (state_reg == ST_WIN);
   assign lost         = (state_reg == ST_LOSE);
   assign seg_display  = seg_reg;

`ifdef UPDOWN_RANGE_TRACK_EN
   assign range_lo = lo_reg;
   assign range_hi = hi_reg;
`else
   logic unused_range;
   assign unused_range = ^{lo_reg, hi_reg};
`endif

endmodule

// File: tb/tb_updown_game_core.sv
// Directed bench for updown_game_core: a default instance (7 tries) and a
// 3-try instance share stimulus; each is only checked in its own phase.
module tb_updown_game_core;

   localparam int G_BLANK = 'h00;
   localparam int G_U     = 'h3E;
   localparam int G_D     = 'h5E;
   localparam int G_C     = 'h39;
   localparam int G_L     = 'h38;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [6:0] secret;
   logic       guess_valid;
   logic [6:0] guess;

   logic       rdy_a, rv_a, err_a, won_a, lost_a;
   logic [1:0] res_a;
   logic [2:0] used_a, left_a;
   logic [6:0] seg_a;
   logic       rdy_b, rv_b, err_b, won_b, lost_b;
   logic [1:0] res_b;
   logic [1:0] used_b, left_b;
   logic [6:0] seg_b;
`ifdef UPDOWN_RANGE_TRACK_EN
   logic [6:0] lo_a, hi_a, lo_b, hi_b;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   updown_game_core u_dut_a (
      .clk(clk), .reset(reset), .start(start), .secret(secret),
      .guess_valid(guess_valid), .guess(guess), .guess_ready(rdy_a),
      .result(res_a), .result_valid(rv_a), .guess_err(err_a),
      .tries_used(used_a), .tries_left(left_a), .won(won_a), .lost(lost_a),
      .seg_display(seg_a)
`ifdef UPDOWN_RANGE_TRACK_EN
      , .range_lo(lo_a), .range_hi(hi_a)
`endif
   );

   updown_game_core #(.MAX_TRIES(3)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .secret(secret),
      .guess_valid(guess_valid), .guess(guess), .guess_ready(rdy_b),
      .result(res_b), .result_valid(rv_b), .guess_err(err_b),
      .tries_used(used_b), .tries_left(left_b), .won(won_b), .lost(lost_b),
      .seg_display(seg_b)
`ifdef UPDOWN_RANGE_TRACK_EN
      , .range_lo(lo_b), .range_hi(hi_b)
`endif
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int s);
      @(negedge clk);
      start  = 1'b1;
      secret = 7'(s);
      @(negedge clk);
      start  = 1'b0;
      $display("start secret=%0d", s);
   endtask

   task automatic do_guess(input int g);
      @(negedge clk);
      guess_valid = 1'b1;
      guess       = 7'(g);
      @(negedge clk);
      guess_valid = 1'b0;
      $display("guess %0d -> A res=%0d rv=%0d err=%0d used=%0d | B res=%0d used=%0d",
               g, res_a, rv_a, err_a, used_a, res_b, used_b);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; secret = '0; guess_valid = 1'b0; guess = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_result", int'(res_a), 0);
      check_eq("rst_rv", int'(rv_a), 0);
      check_eq("rst_err", int'(err_a), 0);
      check_eq("rst_used", int'(used_a), 0);
      check_eq("rst_left", int'(left_a), 7);
      check_eq("rst_won_lost", int'({won_a, lost_a}), 0);
      check_eq("rst_seg", int'(seg_a), G_BLANK);
      check_eq("rst_ready", int'(rdy_a), 0);
      reset = 1'b1;

      // Secret 42: UP, DOWN, CORRECT
      do_start(42);
      check_eq("s42_ready", int'(rdy_a), 1);
      check_eq("s42_used0", int'(used_a), 0);
      do_guess(30);
      check_eq("g30_res", int'(res_a), 1);
      check_eq("g30_rv", int'(rv_a), 1);
      check_eq("g30_used", int'(used_a), 1);
      check_eq("g30_seg", int'(seg_a), G_U);
      @(negedge clk);
      check_eq("g30_rv_drop", int'(rv_a), 0);
      check_eq("g30_res_hold", int'(res_a), 1);
      do_guess(50);
      check_eq("g50_res", int'(res_a), 2);
      check_eq("g50_used", int'(used_a), 2);
      check_eq("g50_seg", int'(seg_a), G_D);
      do_guess(42);
      check_eq("g42_res", int'(res_a), 3);
      check_eq("g42_used", int'(used_a), 3);
      check_eq("g42_left", int'(left_a), 4);
      check_eq("g42_won", int'(won_a), 1);
      check_eq("g42_seg", int'(seg_a), G_C);
      check_eq("g42_ready", int'(rdy_a), 0);
      do_guess(10);
      check_eq("win_no_accept", int'(rv_a), 0);
      check_eq("win_used_hold", int'(used_a), 3);

      // Restart from WIN, illegal guess, back-to-back guesses
      do_start(20);
      check_eq("s20_won", int'(won_a), 0);
      check_eq("s20_used", int'(used_a), 0);
      check_eq("s20_res", int'(res_a), 0);
      check_eq("s20_seg", int'(seg_a), G_BLANK);
      do_guess(120);
      check_eq("g120_err", int'(err_a), 1);
      check_eq("g120_rv", int'(rv_a), 0);
      check_eq("g120_used", int'(used_a), 0);
      check_eq("g120_res", int'(res_a), 0);
      @(negedge clk);
      check_eq("g120_err_drop", int'(err_a), 0);
      guess_valid = 1'b1; guess = 7'd10;
      @(negedge clk);
      check_eq("b2b1_res", int'(res_a), 1);
      check_eq("b2b1_rv", int'(rv_a), 1);
      guess = 7'd30;
      @(negedge clk);
      guess_valid = 1'b0;
      $display("back-to-back guesses 10,30 -> res=%0d used=%0d", res_a, used_a);
      check_eq("b2b2_res", int'(res_a), 2);
      check_eq("b2b2_rv", int'(rv_a), 1);
      check_eq("b2b2_used", int'(used_a), 2);

      // Start and guess together: start wins, guess dropped
      @(negedge clk);
      start = 1'b1; secret = 7'd5; guess_valid = 1'b1; guess = 7'd5;
      @(negedge clk);
      start = 1'b0; guess_valid = 1'b0;
      $display("start+guess secret=5 -> used=%0d rv=%0d", used_a, rv_a);
      check_eq("sg_used", int'(used_a), 0);
      check_eq("sg_rv", int'(rv_a), 0);
      check_eq("sg_err", int'(err_a), 0);
      check_eq("sg_ready", int'(rdy_a), 1);

      // Asynchronous reset mid-PLAY
      do_guess(3);
      check_eq("g3_used", int'(used_a), 1);
      #2 reset = 1'b0;
      #1;
      $display("async reset asserted mid-PLAY");
      check_eq("arst_used", int'(used_a), 0);
      check_eq("arst_left", int'(left_a), 7);
      check_eq("arst_res", int'(res_a), 0);
      check_eq("arst_seg", int'(seg_a), G_BLANK);
      check_eq("arst_ready", int'(rdy_a), 0);
`ifdef UPDOWN_RANGE_TRACK_EN
      check_eq("arst_range", int'({lo_a, hi_a}), 99);
`endif
      @(negedge clk);
      reset = 1'b1;
      do_start(100);
      check_eq("s100_ready", int'(rdy_a), 0);
      do_guess(7);
      check_eq("idle_no_accept", int'(rv_a), 0);

`ifdef UPDOWN_RANGE_TRACK_EN
      do_start(60);
      do_guess(50);
      check_eq("rng_lo", int'(lo_a), 51);
      check_eq("rng_used", int'(used_a), 1);
      do_guess(40);
      check_eq("rng_err", int'(err_a), 1);
      check_eq("rng_used_hold", int'(used_a), 1);
`endif

      // 3-try instance: lose after three misses
      do_start(10);
      do_guess(5);
`ifdef UPDOWN_RANGE_TRACK_EN
      do_guess(6);
      do_guess(7);
`else
      do_guess(5);
      do_guess(5);
`endif
      check_eq("b_lose_res", int'(res_b), 1);
      check_eq("b_lose_lost", int'(lost_b), 1);
      check_eq("b_lose_won", int'(won_b), 0);
      check_eq("b_lose_seg", int'(seg_b), G_L);
      check_eq("b_lose_left", int'(left_b), 0);
      check_eq("b_lose_used", int'(used_b), 3);
      do_guess(10);
      check_eq("b_lose_no_accept", int'(rv_b), 0);
      check_eq("b_lose_used_hold", int'(used_b), 3);

      // 3-try instance: correct on final try is a win
      do_start(10);
      do_guess(1);
      do_guess(2);
      do_guess(10);
      check_eq("b_win_won", int'(won_b), 1);
      check_eq("b_win_lost", int'(lost_b), 0);
      check_eq("b_win_res", int'(res_b), 3);
      check_eq("b_win_used", int'(used_b), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
